// File: rtl/prescaled_counter_pkg.sv
// Shared constants for the prescaled counter: mode encodings and direction values.
package prescaled_counter_pkg;

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prescaled_counter_tick_gen.sv
// Free-running prescaler with a clamped, selectable all-ones match that yields a one-cycle enable.
module prescaled_counter_tick_gen #(
  parameter int PRE_W = 26,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [SEL_W-1:0] div_sel,
  output logic             tick
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(PRE_W - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] prescaler_q;
  logic [PRE_W-1:0] prescaler_d;
  logic [SEL_W-1:0] sel_s;
  logic [PRE_W-1:0] mask_s;

  // Clamp the selector, build the low-bit mask and evaluate the match.
  always_comb begin
    sel_s  = div_sel;
    mask_s = {PRE_W{1'b0}};
    if (div_sel > SEL_MAX) begin
      sel_s = SEL_MAX;
    end else begin
      sel_s = div_sel;
    end
    for (int i = 0; i < PRE_W; i++) begin
      mask_s[i] = (i <= int'(sel_s));
    end
    tick = en & ((prescaler_q & mask_s) == mask_s);
  end

  // A load restarts the period, even while the counter is paused.
  always_comb begin
    prescaler_d = prescaler_q;
    if (clr) begin
      prescaler_d = {PRE_W{1'b0}};
    end else if (en) begin
      prescaler_d = prescaler_q + PRE_ONE;
    end else begin
      prescaler_d = prescaler_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= {PRE_W{1'b0}};
    end else begin
      prescaler_q <= prescaler_d;
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Tick-driven up/down/bounce/hold counter with wrap or saturate, synchronous load and chain pulse.
module prescaled_counter
  import prescaled_counter_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int PRE_W = 26,
  parameter int SEL_W = 5
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             EN,
  input  logic [SEL_W-1:0] DIV_SEL,
  input  logic [1:0]       MODE,
  input  logic             SATURATE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic             TICK,
  output logic             WRAP,
  output logic             DIR
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             t_s;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  prescaled_counter_tick_gen #(
    .PRE_W (PRE_W),
    .SEL_W (SEL_W)
  ) u_tick_gen (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .en      (EN),
    .clr     (LOAD),
    .div_sel (DIV_SEL),
    .tick    (t_s)
  );

  // Step logic: load wins over the tick; boundary steps raise the chain pulse.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (LOAD) begin
      count_d = LOAD_VAL;
    end else if (t_s) begin
      tick_d = 1'b1;
      case (MODE)
        MODE_UP: begin
          dir_d = DIR_UP;
          if (count_q == CNT_MAX) begin
            wrap_d  = 1'b1;
            count_d = SATURATE ? CNT_MAX : CNT_ZERO;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        MODE_DOWN: begin
          dir_d = DIR_DOWN;
          if (count_q == CNT_ZERO) begin
            wrap_d  = 1'b1;
            count_d = SATURATE ? CNT_ZERO : CNT_MAX;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
        MODE_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            if (count_q == CNT_MAX) begin
              count_d = CNT_MAX - CNT_ONE;
              dir_d   = DIR_DOWN;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end else begin
            if (count_q == CNT_ZERO) begin
              count_d = CNT_ONE;
              dir_d   = DIR_UP;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - CNT_ONE;
            end
          end
        end
        MODE_HOLD: begin
          count_d = count_q;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end else begin
      count_d = count_q;
    end
  end

  // Output-facing state registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      count_q <= CNT_ZERO;
      dir_q   <= DIR_UP;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign COUNT = count_q;
  assign TICK  = tick_q;
  assign WRAP  = wrap_q;
  assign DIR   = dir_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter with WIDTH=4, PRE_W=8, SEL_W=3.
module tb_prescaled_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] div_sel;
  logic [1:0] mode;
  logic       saturate;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       tick;
  logic       wrap;
  logic       dir;

  int n_cmp = 0;
  int n_err = 0;

  prescaled_counter #(.WIDTH(4), .PRE_W(8), .SEL_W(3)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .EN       (en),
    .DIV_SEL  (div_sel),
    .MODE     (mode),
    .SATURATE (saturate),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .COUNT    (count),
    .TICK     (tick),
    .WRAP     (wrap),
    .DIR      (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int c, input int t, input int w, input int d);
    check({tag, ".count"}, 32'(count), c);
    check({tag, ".tick"},  32'(tick),  t);
    check({tag, ".wrap"},  32'(wrap),  w);
    check({tag, ".dir"},   32'(dir),   d);
  endtask

  task automatic do_load(input logic [3:0] v);
    load     = 1'b1;
    load_val = v;
    step(1);
    load     = 1'b0;
    check("load.count", 32'(count), 32'(v));
    check("load.tick",  32'(tick),  0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; div_sel = 3'd1; mode = 2'b00;
    saturate = 1'b0; load = 1'b0; load_val = 4'd0;

    // 1. reset and up count with wrap, period 4
    #12;
    check_out("reset", 0, 0, 0, 0);
    step(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step(3);
      check("up.gap_tick", 32'(tick), 0);
      step(1);
      check_out("up", k % 16, 1, (k == 16) ? 1 : 0, 0);
    end
    step(4);
    check_out("up.again", 1, 1, 0, 0);
    rst_n = 1'b0;
    #2;
    check_out("async_reset", 0, 0, 0, 0);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("post_reset.gap", 32'(tick), 0);
    step(1);
    check_out("post_reset.first", 1, 1, 0, 0);

    // 2. saturate up, wrap down
    do_load(4'd14);
    saturate = 1'b1;
    step(4); check_out("sat_up.1", 15, 1, 0, 0);
    step(4); check_out("sat_up.2", 15, 1, 1, 0);
    step(4); check_out("sat_up.3", 15, 1, 1, 0);
    do_load(4'd0);
    mode = 2'b01; saturate = 1'b0;
    step(4); check_out("down_wrap", 15, 1, 1, 1);

    // 3. bounce
    do_load(4'd12);
    mode = 2'b00;
    step(4); check_out("pre_bounce", 13, 1, 0, 0);
    mode = 2'b10;
    step(4); check_out("bounce.14", 14, 1, 0, 0);
    step(4); check_out("bounce.15", 15, 1, 0, 0);
    step(4); check_out("bounce.turn", 14, 1, 1, 1);
    step(4); check_out("bounce.13", 13, 1, 0, 1);
    do_load(4'd1);
    step(4); check_out("bounce.0", 0, 1, 0, 1);
    step(4); check_out("bounce.turn_up", 1, 1, 1, 0);

    // 4. load on the tick edge, then hold mode
    do_load(4'd5);
    mode = 2'b11;
    step(3);
    check("pre_collide.tick", 32'(tick), 0);
    do_load(4'd9);
    step(3);
    check("after_load.gap", 32'(tick), 0);
    step(1);
    check_out("hold_tick", 9, 1, 0, 0);

    // 5. pause mid-period, then load while paused
    mode = 2'b00;
    step(2);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("paused.tick", 32'(tick), 0);
    end
    check("paused.count", 32'(count), 9);
    en = 1'b1;
    step(1);
    check("resume.gap", 32'(tick), 0);
    step(1);
    check_out("resume.tick", 10, 1, 0, 0);
    en = 1'b0;
    do_load(4'd3);
    step(5);
    check("paused_load.count", 32'(count), 3);
    en = 1'b1;
    step(3);
    check("paused_load.gap", 32'(tick), 0);
    step(1);
    check_out("paused_load.tick", 4, 1, 0, 0);

    // 6. longest period, then fast switch mid-period
    div_sel = 3'd7;
    do_load(4'd0);
    step(255);
    check("slow.gap1", 32'(tick), 0);
    step(1);
    check_out("slow.tick1", 1, 1, 0, 0);
    step(255);
    check("slow.gap2", 32'(tick), 0);
    step(1);
    check_out("slow.tick2", 2, 1, 0, 0);
    step(100);
    check("slow.mid", 32'(tick), 0);
    div_sel = 3'd0;
    step(1);
    check("fast.gap", 32'(tick), 0);
    step(1);
    check_out("fast.tick1", 3, 1, 0, 0);
    step(1);
    check("fast.gap2", 32'(tick), 0);
    step(1);
    check_out("fast.tick2", 4, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
